// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// datapath select codes and trap causes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_DONE   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IMM_EXEC = 4'd10,
    S_IMM_DONE = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  function automatic logic is_imm_op(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/multicycle_control_outdec.sv
// Moore output decode: state -> datapath controls, combinational (0 cycles).
// Only FETCH looks at mem_ready, gating ir_write/pc_write on completion.
module multicycle_control_outdec
  import multicycle_control_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       trap
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    pc_source     = PCSRC_ALU;
    alu_op        = ALU_ADD;
    trap          = 1'b0;

    case (state_t'(state))
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMMSH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_R_DONE: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_IMM_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_IMM;
      end
      S_IMM_DONE: begin
        reg_write = 1'b1;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with illegal-opcode and memory-timeout traps.
// Stalls in FETCH/MEM_RD/MEM_WR while mem_ready=0; retired counts completed instructions.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int IMM_EN      = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [5:0]       op_q;
  logic [31:0]      wait_cnt;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] retired_q;
  logic             waiting;
  logic             wait_hit;
  logic             retire;
  logic             imm_ok;
  logic [3:0]       dec_state;

  assign waiting  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign wait_hit = (MEM_TIMEOUT != 0) && (wait_cnt == 32'(MEM_TIMEOUT - 1));
  assign imm_ok   = (IMM_EN != 0) && is_imm_op(opcode);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        // A completing access in the timeout cycle still completes.
        if (mem_ready) begin
          if (state_q == S_FETCH)     state_d = S_DECODE;
          else if (state_q == S_MEM_RD) state_d = S_MEM_WB;
          else                          state_d = S_FETCH;
        end else if (wait_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEM_ADDR;
        else if (opcode == OP_RTYPE)            state_d = S_EXEC;
        else if (opcode == OP_BEQ)              state_d = S_BRANCH;
        else if (opcode == OP_J)                state_d = S_JUMP;
        else if (imm_ok)                        state_d = S_IMM_EXEC;
        else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_EXEC:     state_d = S_R_DONE;
      S_IMM_EXEC: state_d = S_IMM_DONE;
      S_MEM_WB, S_R_DONE, S_BRANCH, S_JUMP, S_IMM_DONE: state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEM_WB, S_R_DONE, S_BRANCH, S_JUMP, S_IMM_DONE: retire = 1'b1;
      S_MEM_WR: retire = mem_ready;
      default:  retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= OP_RTYPE;
      wait_cnt  <= '0;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      wait_cnt <= (waiting && !mem_ready) ? wait_cnt + 32'd1 : 32'd0;
      if (state_q == S_DECODE) op_q <= opcode;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Decode as FETCH while reset is held so controls are defined before the first edge.
  assign dec_state = rst ? S_FETCH : state_q;

  multicycle_control_outdec u_outdec (
    .state         (dec_state),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_source     (pc_source),
    .alu_op        (alu_op),
    .trap          (trap)
  );

  assign state      = state_q;
  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: default instance plus an IMM_EN=0, CNT_W=4 instance.
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Instance a: defaults
  logic       a_rst, a_mr;
  logic [5:0] a_op;
  logic       a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw, a_srca;
  logic [1:0] a_srcb, a_pcs, a_aluop, a_cause;
  logic [3:0] a_state;
  logic       a_trap;
  logic [31:0] a_ret;

  // Instance b: IMM_EN=0, CNT_W=4
  logic       b_rst, b_mr;
  logic [5:0] b_op;
  logic       b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw, b_srca;
  logic [1:0] b_srcb, b_pcs, b_aluop, b_cause;
  logic [3:0] b_state;
  logic       b_trap;
  logic [3:0] b_ret;

  multicycle_control dut_a (
    .clk(clk), .rst(a_rst), .opcode(a_op), .mem_ready(a_mr),
    .pc_write(a_pcw), .pc_write_cond(a_pcwc), .iord(a_iord), .mem_read(a_mrd),
    .mem_write(a_mwr), .ir_write(a_irw), .mem_to_reg(a_m2r), .reg_dst(a_rdst),
    .reg_write(a_rw), .alu_src_a(a_srca), .alu_src_b(a_srcb), .pc_source(a_pcs),
    .alu_op(a_aluop), .state(a_state), .trap(a_trap), .trap_cause(a_cause),
    .retired(a_ret)
  );

  multicycle_control #(.IMM_EN(0), .MEM_TIMEOUT(16), .CNT_W(4)) dut_b (
    .clk(clk), .rst(b_rst), .opcode(b_op), .mem_ready(b_mr),
    .pc_write(b_pcw), .pc_write_cond(b_pcwc), .iord(b_iord), .mem_read(b_mrd),
    .mem_write(b_mwr), .ir_write(b_irw), .mem_to_reg(b_m2r), .reg_dst(b_rdst),
    .reg_write(b_rw), .alu_src_a(b_srca), .alu_src_b(b_srcb), .pc_source(b_pcs),
    .alu_op(b_aluop), .state(b_state), .trap(b_trap), .trap_cause(b_cause),
    .retired(b_ret)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    a_rst = 1'b1; a_mr = 1'b1; a_op = 6'b000000;
    b_rst = 1'b1; b_mr = 1'b1; b_op = 6'b000000;
    tick();
    a_rst = 1'b0;

    // reset state, FETCH decoding with mem_ready=1
    check("rst_state", 32'(a_state), 32'd0);
    check("rst_retired", a_ret, 32'd0);
    check("rst_trap", 32'(a_trap), 32'd0);
    check("rst_cause", 32'(a_cause), 32'd0);
    check("fetch_mem_read", 32'(a_mrd), 32'd1);
    check("fetch_srcb", 32'(a_srcb), 32'd1);
    check("fetch_pc_write", 32'(a_pcw), 32'd1);
    check("fetch_ir_write", 32'(a_irw), 32'd1);

    // add: 0,1,6,7,0
    tick(); check("add_decode", 32'(a_state), 32'd1);
    check("decode_srcb", 32'(a_srcb), 32'd3);
    tick(); check("add_exec", 32'(a_state), 32'd6);
    check("exec_aluop", 32'(a_aluop), 32'd2);
    check("exec_srca", 32'(a_srca), 32'd1);
    tick(); check("add_rdone", 32'(a_state), 32'd7);
    check("rdone_regdst", 32'(a_rdst), 32'd1);
    check("rdone_regwrite", 32'(a_rw), 32'd1);
    check("rdone_retired", a_ret, 32'd0);
    tick(); check("add_fetch", 32'(a_state), 32'd0);
    check("add_retired", a_ret, 32'd1);

    // lw with three wait cycles in MEM_RD: 8 cycles total
    a_op = 6'b100011;
    tick(); check("lw_decode", 32'(a_state), 32'd1);
    tick(); check("lw_addr", 32'(a_state), 32'd2);
    check("addr_srcb", 32'(a_srcb), 32'd2);
    tick(); check("lw_rd1", 32'(a_state), 32'd3);
    check("rd_iord", 32'(a_iord), 32'd1);
    a_mr = 1'b0;
    check("fetch_pcw_gated", 32'(a_pcw), 32'd0);
    tick(); check("lw_rd2", 32'(a_state), 32'd3);
    tick(); check("lw_rd3", 32'(a_state), 32'd3);
    tick(); check("lw_rd4", 32'(a_state), 32'd3);
    a_mr = 1'b1;
    tick(); check("lw_wb", 32'(a_state), 32'd4);
    check("wb_mem_to_reg", 32'(a_m2r), 32'd1);
    check("wb_reg_write", 32'(a_rw), 32'd1);
    tick(); check("lw_fetch", 32'(a_state), 32'd0);
    check("lw_retired", a_ret, 32'd2);

    // illegal opcode traps, held until reset
    a_op = 6'b111111;
    tick(); check("ill_decode", 32'(a_state), 32'd1);
    tick(); check("ill_trap", 32'(a_state), 32'd15);
    check("ill_trap_out", 32'(a_trap), 32'd1);
    check("ill_cause", 32'(a_cause), 32'd1);
    check("ill_retired", a_ret, 32'd2);
    check("trap_mem_read", 32'(a_mrd), 32'd0);
    tick(); tick(); tick();
    check("ill_stuck", 32'(a_state), 32'd15);
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    check("trap_rst_state", 32'(a_state), 32'd0);
    check("trap_rst_cause", 32'(a_cause), 32'd0);
    check("trap_rst_retired", a_ret, 32'd0);

    // ori: 0,1,10,11,0
    a_op = 6'b001101;
    tick(); check("ori_decode", 32'(a_state), 32'd1);
    tick(); check("ori_exec", 32'(a_state), 32'd10);
    check("ori_aluop", 32'(a_aluop), 32'd3);
    tick(); check("ori_done", 32'(a_state), 32'd11);
    check("ori_regwrite", 32'(a_rw), 32'd1);
    check("ori_regdst", 32'(a_rdst), 32'd0);
    tick(); check("ori_fetch", 32'(a_state), 32'd0);
    check("ori_retired", a_ret, 32'd1);

    // FETCH timeout after 16 low cycles
    a_mr = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("to_15_low", 32'(a_state), 32'd0);
    tick(); check("to_trap", 32'(a_state), 32'd15);
    check("to_cause", 32'(a_cause), 32'd2);
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;

    // mem_ready on the 16th cycle wins over the timeout
    for (int i = 0; i < 15; i++) tick();
    check("to_edge_wait", 32'(a_state), 32'd0);
    a_mr = 1'b1;
    a_op = 6'b000010;
    tick(); check("to_edge_decode", 32'(a_state), 32'd1);
    tick(); check("j_state", 32'(a_state), 32'd9);
    check("j_pcw", 32'(a_pcw), 32'd1);
    check("j_pcsrc", 32'(a_pcs), 32'd2);
    tick(); check("j_fetch", 32'(a_state), 32'd0);
    check("j_retired", a_ret, 32'd1);

    // instance b: addi illegal when IMM_EN=0
    b_rst = 1'b1; b_mr = 1'b1; b_op = 6'b001000;
    tick();
    b_rst = 1'b0;
    tick(); check("b_addi_decode", 32'(b_state), 32'd1);
    tick(); check("b_addi_trap", 32'(b_state), 32'd15);
    check("b_addi_cause", 32'(b_cause), 32'd1);
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;

    // 4-bit retired wraps after 16 jumps
    b_op = 6'b000010;
    for (int i = 0; i < 15; i++) begin
      tick(); tick(); tick();
    end
    check("b_ret_15", 32'(b_ret), 32'd15);
    tick(); tick(); tick();
    check("b_ret_wrap", 32'(b_ret), 32'd0);

    // sw, reset asserted while in MEM_WR
    b_op = 6'b101011;
    tick(); check("b_sw_decode", 32'(b_state), 32'd1);
    tick(); check("b_sw_addr", 32'(b_state), 32'd2);
    tick(); check("b_sw_wr", 32'(b_state), 32'd5);
    b_mr = 1'b0;
    check("b_sw_mem_write", 32'(b_mwr), 32'd1);
    b_rst = 1'b1;
    tick();
    check("b_rst_state", 32'(b_state), 32'd0);
    check("b_rst_mem_write", 32'(b_mwr), 32'd0);
    check("b_rst_retired", 32'(b_ret), 32'd0);
    b_rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
